ff: RTL and testbench



---
 rtl/ff_if.sv | 21 ++
 rtl/ff.sv | 30 +++
 tb/tb_ff.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ff_if.sv
// Write/read bundle for the enable-gated storage register.
// The master side drives the load enable and data; the slave side returns the stored word.
interface ff_if #(
   parameter int WIDTH = 1
);
   logic             write_en_i;
   logic [WIDTH-1:0] write_data_i;
   logic [WIDTH-1:0] read_data_o;

   modport master (
      output write_en_i,
      output write_data_i,
      input  read_data_o
   );

   modport slave (
      input  write_en_i,
      input  write_data_i,
      output read_data_o
   );
endinterface

// File: rtl/ff.sv
// Enable-gated WIDTH-bit D flip-flop bank with synchronous reset.
// The output comes straight from the register, so no input reaches it combinationally.
module ff #(
   parameter int WIDTH = 1
) (
   input  logic clk,
   input  logic rst,
   ff_if.slave  bus
);
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (bus.write_en_i) begin
         data_d = bus.write_data_i;
      end
   end

   // Reset takes priority over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign bus.read_data_o = data_q;
endmodule

// File: tb/tb_ff.sv
// Self-checking bench for ff at WIDTH = 1, 8 and 32.
// Table vectors plus two mid-cycle corner sequences feed a one-deep scoreboard.
module tb_ff;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst8, rst32;

   ff_if #(.WIDTH(1))  b1 ();
   ff_if #(.WIDTH(8))  b8 ();
   ff_if #(.WIDTH(32)) b32 ();

   ff #(.WIDTH(1))  u_ff1  (.clk(clk), .rst(rst1),  .bus(b1.slave));
   ff #(.WIDTH(8))  u_ff8  (.clk(clk), .rst(rst8),  .bus(b8.slave));
   ff #(.WIDTH(32)) u_ff32 (.clk(clk), .rst(rst32), .bus(b32.slave));

   typedef struct {
      int          sel;
      logic        r;
      logic        we;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      int          idx;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic logic [31:0] read_out(input int sel);
      case (sel)
         1:       return {31'd0, b1.read_data_o};
         8:       return {24'd0, b8.read_data_o};
         default: return b32.read_data_o;
      endcase
   endfunction

   task automatic drive(input int sel, input logic r, input logic we, input logic [31:0] d);
      rst1 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
      b1.write_en_i = 1'b0; b8.write_en_i = 1'b0; b32.write_en_i = 1'b0;
      case (sel)
         1: begin rst1 = r; b1.write_en_i = we; b1.write_data_i = d[0]; end
         8: begin rst8 = r; b8.write_en_i = we; b8.write_data_i = d[7:0]; end
         default: begin rst32 = r; b32.write_en_i = we; b32.write_data_i = d; end
      endcase
   endtask

   task automatic check_pending();
      sb_t         e;
      logic [31:0] act;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = read_out(e.sel);
         n_cmp++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL step%0d w%0d: read_data_o got %h want %h", e.idx, e.sel, act, e.exp);
         end
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // width-1 corner
      vecs.push_back('{1, 1'b1, 1'b1, 32'h1, 32'h0});
      vecs.push_back('{1, 1'b0, 1'b1, 32'h1, 32'h1});
      vecs.push_back('{1, 1'b0, 1'b1, 32'h0, 32'h0});
      vecs.push_back('{1, 1'b0, 1'b1, 32'h1, 32'h1});
      vecs.push_back('{1, 1'b0, 1'b0, 32'h0, 32'h1});
      // width-32 corner
      vecs.push_back('{32, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{32, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
      for (int i = 0; i < 3; i++) vecs.push_back('{32, 1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF});
      // width-8: reset with all-ones data, basic write, hold
      vecs.push_back('{8, 1'b1, 1'b1, 32'hFF, 32'h00});
      vecs.push_back('{8, 1'b1, 1'b1, 32'hFF, 32'h00});
      vecs.push_back('{8, 1'b0, 1'b1, 32'hA5, 32'hA5});
      for (int i = 0; i < 5; i++) vecs.push_back('{8, 1'b0, 1'b0, 32'h3C, 32'hA5});
      // back-to-back writes
      vecs.push_back('{8, 1'b0, 1'b1, 32'h01, 32'h01});
      vecs.push_back('{8, 1'b0, 1'b1, 32'h02, 32'h02});
      vecs.push_back('{8, 1'b0, 1'b1, 32'hFF, 32'hFF});
      vecs.push_back('{8, 1'b0, 1'b1, 32'h00, 32'h00});
      // reset beats a simultaneous write, then the next write loads
      vecs.push_back('{8, 1'b0, 1'b1, 32'h5A, 32'h5A});
      vecs.push_back('{8, 1'b1, 1'b1, 32'h77, 32'h00});
      vecs.push_back('{8, 1'b0, 1'b1, 32'h77, 32'h77});

      drive(8, 1'b0, 1'b0, 32'h0);
      b1.write_data_i = 1'b0;
      b32.write_data_i = 32'h0;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         check_pending();
         drive(vecs[i].sel, vecs[i].r, vecs[i].we, vecs[i].d);
         sb.push_back('{vecs[i].sel, vecs[i].exp, i});
      end

      // rst pulsed between edges must not reach the register
      @(posedge clk); #1;
      check_pending();
      drive(8, 1'b0, 1'b0, 32'h00);
      sb.push_back('{8, 32'h77, 100});
      #3 rst8 = 1'b1;
      #2 rst8 = 1'b0;

      // enable dropped before the edge: the presented data is not captured
      @(posedge clk); #1;
      check_pending();
      drive(8, 1'b0, 1'b1, 32'h11);
      sb.push_back('{8, 32'h77, 101});
      #3 b8.write_en_i = 1'b0;

      @(posedge clk); #1;
      check_pending();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
